// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per clock, unsigned or
// two's complement operands, full 2*WIDTH-bit product, start/ready handshake.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sign,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               ready
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Conditional two's-complement negate; also yields |x| of a sign-extended operand.
  function automatic logic [PW-1:0] negate_if(input logic [PW-1:0] v, input logic neg);
    return neg ? (~v + PW'(1)) : v;
  endfunction

  state_e          state;
  logic [PW-1:0]   mag_a;
  logic [PW-1:0]   mag_b;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   count;
  logic            neg;

  logic [PW-1:0]   ext_a, ext_b;
  logic [PW-1:0]   abs_a, abs_b;

  // Operand magnitudes, taken at the full product width so -2^(W-1) stays exact.
  always_comb begin
    ext_a = sign ? {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand}
                 : {{WIDTH{1'b0}}, multiplicand};
    ext_b = sign ? {{WIDTH{multiplier[WIDTH-1]}}, multiplier}
                 : {{WIDTH{1'b0}}, multiplier};
    abs_a = negate_if(ext_a, sign & multiplicand[WIDTH-1]);
    abs_b = negate_if(ext_b, sign & multiplier[WIDTH-1]);
  end

  // NOTE: all state is assigned with <= so every register sees pre-edge values;
  // the FIN write-back and a same-edge restart therefore never race.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      product <= '0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      mag_a   <= '0;
      mag_b   <= '0;
      acc     <= '0;
      count   <= '0;
      neg     <= 1'b0;
    end else begin
      ready <= 1'b0;

      // The finished result is delivered even if a new start arrives this cycle.
      if (state == FIN) begin
        product <= negate_if(acc, neg);
        ready   <= 1'b1;
      end

      if (start) begin
        // Restart from any state; an aborted RUN never reaches the write-back.
        mag_a <= abs_a;
        mag_b <= abs_b;
        neg   <= sign & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
        acc   <= '0;
        count <= CW'(WIDTH);
        busy  <= 1'b1;
        state <= RUN;
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          RUN: begin
            // mag_a is pre-shifted each step instead of shifting by WIDTH-count.
            if (mag_b[0]) acc <= acc + mag_a;
            mag_a <= mag_a << 1;
            mag_b <= mag_b >> 1;
            count <= count - CW'(1);
            if (count == CW'(1)) state <= FIN;
          end
          FIN: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier (WIDTH=8): the driver queues expected
// products and ready cycles, a negedge monitor pops and compares on ready.
module tb_seq_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           sign;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic [2*W-1:0] product;
  logic           busy;
  logic           ready;

  typedef struct {
    logic [2*W-1:0] prod;
    int             cyc;
    string          name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic prev_ready = 1'b0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .sign         (sign),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .ready        (ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Called on a negedge; start is sampled on the following posedge E0 and the
  // ready pulse is visible after edge E9, i.e. at cyc == now + 10.
  task automatic issue(input string name, input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic push, input logic [2*W-1:0] p);
    exp_t e;
    sign = s; multiplicand = a; multiplier = b; start = 1'b1;
    if (push) begin
      e.prod = p; e.cyc = cyc + 10; e.name = name;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    multiplicand = $urandom_range(0, 255);
    multiplier   = $urandom_range(0, 255);
    sign         = ~s;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(n >= 60), 64'd0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ready) begin
      check("ready_one_cycle", 64'(prev_ready), 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_ready", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_product"}, 64'(product), 64'(e.prod));
        check({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
      end
    end
    prev_ready = ready;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0]   ra, rb;
    logic           rs;
    logic [2*W-1:0] rp;

    reset = 1'b1; start = 1'b0; sign = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (3) @(negedge clk);
    // Reset overrides start.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("reset_product", 64'(product), 64'd0);
    check("reset_busy",    64'(busy),    64'd0);
    check("reset_ready",   64'(ready),   64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors with hand-computed products.
    issue("u_ff_ff", 1'b0, 8'hFF, 8'hFF, 1'b1, 16'hFE01);
    check("busy_running", 64'(busy), 64'd1);
    wait_done();
    issue("s_m3_7",    1'b1, 8'hFD, 8'h07, 1'b1, 16'hFFEB); wait_done();
    issue("s_min_min", 1'b1, 8'h80, 8'h80, 1'b1, 16'h4000); wait_done();
    issue("s_min_1",   1'b1, 8'h80, 8'h01, 1'b1, 16'hFF80); wait_done();
    issue("s_zero",    1'b1, 8'h00, 8'h9C, 1'b1, 16'h0000); wait_done();
    issue("s_m1_m1",   1'b1, 8'hFF, 8'hFF, 1'b1, 16'h0001); wait_done();
    issue("s_max_min", 1'b1, 8'h7F, 8'h80, 1'b1, 16'hC080); wait_done();
    issue("u_12_13",   1'b0, 8'h0C, 8'h0D, 1'b1, 16'h009C); wait_done();
    issue("u_min_min", 1'b0, 8'h80, 8'h80, 1'b1, 16'h4000); wait_done();
    issue("u_ident",   1'b0, 8'h01, 8'hC8, 1'b1, 16'h00C8); wait_done();
    check("idle_busy", 64'(busy), 64'd0);

    // Abort: restart mid-RUN; only the second result appears, old product holds.
    issue("abort_old", 1'b0, 8'd5, 8'd6, 1'b0, '0);
    repeat (2) @(negedge clk);
    issue("abort_new", 1'b0, 8'd10, 8'd10, 1'b1, 16'h0064);
    repeat (4) @(negedge clk);
    check("abort_product_held", 64'(product), 64'h00C8);
    wait_done();

    // Back-to-back: second start lands in the FIN cycle of the first.
    issue("b2b_first", 1'b1, 8'hF6, 8'h0C, 1'b1, 16'hFF88);
    repeat (8) @(negedge clk);
    issue("b2b_second", 1'b0, 8'h0F, 8'h11, 1'b1, 16'h00FF);
    wait_done();

    // Reset mid-operation clears product and suppresses the pulse.
    issue("reset_mid", 1'b0, 8'h33, 8'h44, 1'b0, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_product", 64'(product), 64'd0);
    check("rst_mid_busy",    64'(busy),    64'd0);
    check("rst_mid_ready",   64'(ready),   64'd0);
    repeat (14) @(negedge clk);
    check("rst_mid_still_idle", 64'(busy), 64'd0);

    // Random operands against an arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      if (rs) rp = 16'($signed({{8{ra[7]}}, ra}) * $signed({{8{rb[7]}}, rb}));
      else    rp = 16'({8'h00, ra} * {8'h00, rb});
      issue("rand", rs, ra, rb, 1'b1, rp);
      wait_done();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Iterative shift-add multiplier, the counterpart to the restoring divider in the arithmetic library. Computes a full-width 2·WIDTH-bit product of two WIDTH-bit operands, unsigned or two's complement, one multiplier bit per clock. Uses the divider's start/ready handshake so scanner datapath blocks can drive either unit the same way.

## Interface
- WIDTH, 8, operand width; legal range 2..32.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- sign  in  1  0 = unsigned operands, 1 = two's complement; sampled with start.
- start  in  1  one-cycle request; operands are captured on the edge where start=1.
- multiplicand  in  WIDTH  operand A.
- multiplier  in  WIDTH  operand B.
- product  out  2·WIDTH  A·B, registered; holds its last value until the next result is written.
- busy  out  1  high while an operation is in progress.
- ready  out  1  one-cycle pulse: product is valid this cycle.

## Operation
- States: IDLE, RUN, FIN. State encodings are module-local localparams.
- IDLE: busy=0. On start, go to RUN.
- Capture on start: mag_a = |A| and mag_b = |B| (two's-complement negation when sign=1 and the operand MSB=1; otherwise unchanged, zero-extended). neg = sign & (A[W-1] ^ B[W-1]). acc = 0. count = WIDTH.
- RUN, once per cycle: if mag_b[0]=1, acc += mag_a << (WIDTH-count). Then mag_b >>= 1 and count -= 1. When count reaches 0, go to FIN.
- FIN: product = neg ? (~acc + 1) : acc; ready=1 for this one cycle; return to IDLE.
- Arithmetic: acc is 2·WIDTH bits and cannot overflow, because |A|,|B| ≤ 2^(W-1) when signed and < 2^W when unsigned. The signed case −2^(W-1)·−2^(W-1) = 2^(2W-2) is exact. A zero operand produces 0 with neg ignored; the result is never −0.
- start during RUN or FIN: abort the current operation and restart with the new operands. No ready pulse is produced for the aborted operation, and product keeps its previous value.
- start in the same cycle as FIN: the FIN result is written and ready pulses. The new operands are captured on that same edge and the block enters RUN.
- Operand inputs are ignored except on a start edge. Changing them mid-operation has no effect.

## Timing
- Reset values: product=0, ready=0, busy=0, state=IDLE. Reset overrides start.
- Reset mid-operation: returns to IDLE on the next edge, product is cleared to 0, and no ready pulse is produced.
- Latency: start sampled at edge E0 puts RUN on edges E1..E_WIDTH. FIN is the cycle after E_WIDTH: ready=1 and product is valid from edge E_WIDTH+1 until the next result is written.
- The earliest new start is accepted in the FIN cycle, so back-to-back throughput is one result per WIDTH+1 cycles.
- busy is 1 from the edge after start until the edge that enters IDLE.

## Structure
- Single module, no sub-modules.
- No shared package is needed. WIDTH is the only cross-block constant and is passed by parameter.
- The absolute-value/negate helper is a local function, used for both operand capture and the result sign fix-up.

## Test plan
- Unsigned, WIDTH=8: A=0xFF, B=0xFF, sign=0 -> product=0xFE01; ready pulses exactly 9 cycles after the start edge, for 1 cycle.
- Signed: A=0xFD (−3), B=0x07, sign=1 -> product=0xFFEB (−21). Also A=0x80, B=0x80 -> 0x4000; A=0x80, B=0x01 -> 0xFF80.
- Zero and identity: A=0x00, B=0x9C, sign=1 -> 0x0000. A=0x01, B=0xC8, sign=0 -> 0x00C8.
- Abort: start A=5, B=6; at cycle 4 start A=10, B=10 -> a single ready pulse, 9 cycles after the second start, with product=0x0064; product shows the old value until then.
- Back-to-back and reset: start asserted in the FIN cycle -> both results are delivered, pulses 9 cycles apart. Reset asserted at cycle 3 of an operation -> next cycle product=0, busy=0, ready=0, and no pulse follows.
- Randomized check: 10k random operands for both sign modes at WIDTH=8 and WIDTH=16 against a reference product; ready is never high for two consecutive cycles.
